// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if -- data-memory request/grant/rvalid port.
//
// master: the pipeline stage (drives request, address, data, enables)
// slave : the data memory (drives grant, read-valid, read data)

interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage -- RV32I pipeline stage 3 (memory access).
//
// Takes the execute-stage record plus its memory sideband, runs loads and
// stores on a req/gnt/rvalid data-memory port, formats load data and
// registers the result into the write-back record. Holds the upstream
// pipeline (stall) while an access is outstanding.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid, in_bus    execute-stage record (ex_out = address, rf_rdata2 = store data)
//   mem_rd, mem_wr      load / store strobes (mutually exclusive)
//   mem_size, mem_uns   access size (0 byte, 1 half, 2 word), zero-extend load
//   stall               upstream must hold its inputs stable
//   out_valid, out_bus  write-back record
//   dmem                data-memory port (master side of mem_access_stage_if)
//   bus_err             one-cycle pulse: access aborted by timeout
//   misalign            one-cycle pulse: misaligned access trapped
//
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses instead of silently aligning the address.

package mem_access_stage_pkg;

    typedef struct packed {
        logic        rf_wr_en;
        logic [4:0]  rd;
        logic [1:0]  sel_rf_wr;
        logic        sel_pc;
        logic        cmp_out;
        logic [31:0] inc_pc;
        logic        ecall;
        logic        sel_res;
        logic [31:0] ex_out;
        logic [31:0] rf_rdata2;
    } bus_stage2;

    typedef struct packed {
        logic        rf_wr_en;
        logic [4:0]  rd;
        logic [1:0]  sel_rf_wr;
        logic        sel_pc;
        logic        cmp_out;
        logic [31:0] inc_pc;
        logic        ecall;
        logic [31:0] result;
    } bus_stage3;

endpackage

module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  bus_stage2            in_bus,
    input  logic                 mem_rd,
    input  logic                 mem_wr,
    input  logic [1:0]           mem_size,
    input  logic                 mem_uns,
    output logic                 stall,
    output logic                 out_valid,
    output bus_stage3            out_bus,
    mem_access_stage_if.master   dmem,
    output logic                 bus_err,
    output logic                 misalign
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;

    logic        mem_op;
    logic        trap;
    logic        timeout;
    logic        req;
    logic        store_done;
    logic        load_done;
    logic        complete;
    logic        is_word;
    logic        is_half;
    logic [31:0] addr;
    logic [1:0]  a;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] ld_shift;
    logic [31:0] ld_data;

    assign mem_op  = in_valid & (mem_rd | mem_wr);
    // size 3 is not a legal encoding; treat it as a word
    assign is_word = mem_size[1];
    assign is_half = (mem_size == 2'd1);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = mem_op & ((is_word & (in_bus.ex_out[1:0] != 2'b00)) |
                            (is_half & in_bus.ex_out[0]));
    assign addr = in_bus.ex_out;
`else
    assign trap = 1'b0;
    // Misaligned accesses are forced onto their natural boundary.
    always_comb begin
        addr = in_bus.ex_out;
        if (is_word)      addr[1:0] = 2'b00;
        else if (is_half) addr[0]   = 1'b0;
    end
`endif

    assign a = addr[1:0];

    // Store lane replication and byte enables (loads use the same enables)
    always_comb begin
        wdata = in_bus.rf_rdata2;
        be    = 4'hF;
        if (is_word) begin
            wdata = in_bus.rf_rdata2;
            be    = 4'hF;
        end else if (is_half) begin
            wdata = {2{in_bus.rf_rdata2[15:0]}};
            be    = 4'b0011 << a;
        end else begin
            wdata = {4{in_bus.rf_rdata2[7:0]}};
            be    = 4'b0001 << a;
        end
    end

    // Load alignment and extension
    assign ld_shift = dmem.dmem_rdata >> {a, 3'b000};

    always_comb begin
        ld_data = ld_shift;
        if (is_half)
            ld_data = {{16{~mem_uns & ld_shift[15]}}, ld_shift[15:0]};
        else if (!is_word)
            ld_data = {{24{~mem_uns & ld_shift[7]}}, ld_shift[7:0]};
    end

    assign timeout = mem_op & (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    // FSM next state and completion
    always_comb begin
        state_d    = state_q;
        store_done = 1'b0;
        load_done  = 1'b0;
        req        = mem_op & (state_q == IDLE) & ~trap & ~rst;
        case (state_q)
            IDLE: begin
                store_done = req & mem_wr & dmem.dmem_gnt;
                if (req & mem_rd & dmem.dmem_gnt)
                    state_d = WAIT;
            end
            WAIT: begin
                // gnt is meaningless here; only rvalid ends the load
                load_done = in_valid & mem_rd & dmem.dmem_rvalid;
                if (load_done)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (timeout)
            state_d = IDLE;
        complete = (in_valid & ~mem_op) | trap | store_done | load_done | timeout;
        stall    = mem_op & ~complete;
    end

    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = mem_wr;
    assign dmem.dmem_addr  = addr;
    assign dmem.dmem_wdata = wdata;
    assign dmem.dmem_be    = be;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_bus   <= '0;
            bus_err   <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_valid <= complete;
            bus_err   <= timeout;
            misalign  <= trap;

            if (complete)   cnt_q <= '0;
            else if (stall) cnt_q <= cnt_q + 1'b1;

            if (complete) begin
                out_bus.rf_wr_en  <= in_bus.rf_wr_en & ~timeout & ~trap;
                out_bus.rd        <= in_bus.rd;
                out_bus.sel_rf_wr <= in_bus.sel_rf_wr;
                out_bus.sel_pc    <= in_bus.sel_pc;
                out_bus.cmp_out   <= in_bus.cmp_out;
                out_bus.inc_pc    <= in_bus.inc_pc;
                out_bus.ecall     <= in_bus.ecall;
                if (timeout | trap)
                    out_bus.result <= 32'h0;
                else if (in_bus.sel_res)
                    out_bus.result <= ld_data;
                else
                    out_bus.result <= in_bus.ex_out;
            end else begin
                // bubble: only the side-effecting fields need clearing
                out_bus.rf_wr_en <= 1'b0;
                out_bus.ecall    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table through a scoreboard, with a
// small behavioural memory whose grant / read-valid delays are set per vector.

module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      in_valid;
    bus_stage2 in_bus;
    logic      mem_rd, mem_wr, mem_uns;
    logic [1:0] mem_size;
    logic      stall, out_valid, bus_err, misalign;
    bus_stage3 out_bus;

    mem_access_stage_if dmem ();

    mem_access_stage #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bus(in_bus),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_size(mem_size), .mem_uns(mem_uns),
        .stall(stall), .out_valid(out_valid), .out_bus(out_bus),
        .dmem(dmem.master), .bus_err(bus_err), .misalign(misalign)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural memory ----------------
    int          gnt_dly, rv_dly;
    logic        rv_never;
    logic [31:0] mem_rdata;
    int          req_cnt = 0;
    int          rv_cnt  = 0;
    logic        pend    = 1'b0;

    assign dmem.dmem_gnt    = dmem.dmem_req && (req_cnt >= gnt_dly);
    assign dmem.dmem_rvalid = pend && (rv_cnt >= rv_dly);
    assign dmem.dmem_rdata  = dmem.dmem_rvalid ? mem_rdata : 32'h5A5A5A5A;

    always @(posedge clk) begin
        if (dmem.dmem_req && !dmem.dmem_gnt) req_cnt <= req_cnt + 1;
        else                                 req_cnt <= 0;
        if (pend) begin
            if (dmem.dmem_rvalid) pend <= 1'b0;
            else                  rv_cnt <= rv_cnt + 1;
        end else if (dmem.dmem_req && dmem.dmem_gnt && !dmem.dmem_we && !rv_never) begin
            pend   <= 1'b1;
            rv_cnt <= 0;
        end
    end

    // ---------------- checking ----------------
    typedef struct {
        string       nm;
        logic [31:0] result;
        logic        wen;
        logic [4:0]  rd;
        logic        err;
        logic        mis;
    } exp_t;

    typedef struct {
        string       nm;
        logic        rd_op, wr_op;
        logic [1:0]  size;
        logic        uns, sel_res;
        logic [31:0] addr, wd, mrd;
        int          gd, rvd;
        logic        rvn;
        logic [31:0] res;
        logic        wen, err, mis, req;
        logic [3:0]  be;
        logic [31:0] ewd, eaddr;
        int          stl;
    } vec_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic mon();
        exp_t e;
        if (out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got result %h expected no output", out_bus.result);
            end else begin
                e = sbq.pop_front();
                chk({e.nm, ".result"},   out_bus.result,   e.result);
                chk({e.nm, ".rf_wr_en"}, 32'(out_bus.rf_wr_en), 32'(e.wen));
                chk({e.nm, ".rd"},       32'(out_bus.rd),  32'(e.rd));
                chk({e.nm, ".bus_err"},  32'(bus_err),     32'(e.err));
                chk({e.nm, ".misalign"}, 32'(misalign),    32'(e.mis));
            end
        end else begin
            chk("idle_pulses", {30'b0, bus_err, misalign}, 32'h0);
        end
    endtask

    task automatic neg();
        @(negedge clk);
        mon();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string nm, input logic rd_op, input logic wr_op,
                                input logic [1:0] size, input logic uns, input logic sel_res,
                                input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] mrd,
                                input int gd, input int rvd, input logic rvn,
                                input logic [31:0] res, input logic wen, input logic err,
                                input logic mis, input logic req, input logic [3:0] be,
                                input logic [31:0] ewd, input logic [31:0] eaddr, input int stl);
        vec_t v;
        v.nm = nm; v.rd_op = rd_op; v.wr_op = wr_op; v.size = size; v.uns = uns;
        v.sel_res = sel_res; v.addr = addr; v.wd = wd; v.mrd = mrd; v.gd = gd;
        v.rvd = rvd; v.rvn = rvn; v.res = res; v.wen = wen; v.err = err; v.mis = mis;
        v.req = req; v.be = be; v.ewd = ewd; v.eaddr = eaddr; v.stl = stl;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        int   stalls;
        bit   done;
        gnt_dly   = v.gd;
        rv_dly    = v.rvd;
        rv_never  = v.rvn;
        mem_rdata = v.mrd;
        in_valid  = 1'b1;
        mem_rd    = v.rd_op;
        mem_wr    = v.wr_op;
        mem_size  = v.size;
        mem_uns   = v.uns;
        in_bus           = '0;
        in_bus.rf_wr_en  = ~v.wr_op;
        in_bus.rd        = 5'(idx + 1);
        in_bus.inc_pc    = 32'(idx * 4);
        in_bus.sel_res   = v.sel_res;
        in_bus.ex_out    = v.addr;
        in_bus.rf_rdata2 = v.wd;
        e.nm = v.nm; e.result = v.res; e.wen = v.wen; e.rd = 5'(idx + 1);
        e.err = v.err; e.mis = v.mis;
        sbq.push_back(e);
        stalls = 0;
        done   = 1'b0;
        while (!done) begin
            neg();
            if (stalls == 0 && (v.rd_op || v.wr_op)) begin
                chk({v.nm, ".req"}, 32'(dmem.dmem_req), 32'(v.req));
                if (v.req) begin
                    chk({v.nm, ".addr"}, dmem.dmem_addr, v.eaddr);
                    chk({v.nm, ".be"},   32'(dmem.dmem_be), 32'(v.be));
                    chk({v.nm, ".we"},   32'(dmem.dmem_we), 32'(v.wr_op));
                    if (v.wr_op) chk({v.nm, ".wdata"}, dmem.dmem_wdata, v.ewd);
                end
            end
            if (!stall) done = 1'b1;
            else        stalls++;
            if (stalls > 50) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s.completion: got no completion in 50 cycles expected %0d stalls", v.nm, v.stl);
                done = 1'b1;
            end
            step();
        end
        chk({v.nm, ".stall_cycles"}, 32'(stalls), 32'(v.stl));
    endtask

    vec_t v[15];

    initial begin
        rst = 1'b1; in_valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0;
        mem_size = 2'd2; mem_uns = 1'b0; in_bus = '0;
        gnt_dly = 0; rv_dly = 0; rv_never = 1'b0; mem_rdata = '0;

        // table: name rd wr size uns sel addr wdata mem_rdata gdly rvdly never | result wen err mis req be wdata addr stalls
        v[0]  = mk("alu0",   0,0,2'd2,0,0, 32'h1234,0,0, 0,0,0, 32'h1234,1,0,0, 0,4'h0,0,0, 0);
        v[1]  = mk("alu1",   0,0,2'd2,0,0, 32'h5678,0,0, 0,0,0, 32'h5678,1,0,0, 0,4'h0,0,0, 0);
        v[2]  = mk("sb",     0,1,2'd0,0,0, 32'h1003,32'hAB,0, 0,0,0, 32'h1003,0,0,0, 1,4'b1000,32'hABABABAB,32'h1003, 0);
        v[3]  = mk("sh",     0,1,2'd1,0,0, 32'h1002,32'h0000BEEF,0, 0,0,0, 32'h1002,0,0,0, 1,4'b1100,32'hBEEFBEEF,32'h1002, 0);
        v[4]  = mk("sw",     0,1,2'd2,0,0, 32'h1000,32'h12345678,0, 0,0,0, 32'h1000,0,0,0, 1,4'hF,32'h12345678,32'h1000, 0);
        v[5]  = mk("lh",     1,0,2'd1,0,1, 32'h2002,0,32'h80010000, 2,0,0, 32'hFFFF8001,1,0,0, 1,4'b1100,0,32'h2002, 3);
        v[6]  = mk("lhu",    1,0,2'd1,1,1, 32'h2002,0,32'h80010000, 2,0,0, 32'h00008001,1,0,0, 1,4'b1100,0,32'h2002, 3);
        v[7]  = mk("lb",     1,0,2'd0,0,1, 32'h2001,0,32'h00008000, 0,0,0, 32'hFFFFFF80,1,0,0, 1,4'b0010,0,32'h2001, 1);
        v[8]  = mk("lbu",    1,0,2'd0,1,1, 32'h2003,0,32'hF0000000, 0,0,0, 32'h000000F0,1,0,0, 1,4'b1000,0,32'h2003, 1);
        v[9]  = mk("lw_rv1", 1,0,2'd2,0,1, 32'h2000,0,32'hDEADBEEF, 0,1,0, 32'hDEADBEEF,1,0,0, 1,4'hF,0,32'h2000, 2);
        v[10] = mk("lw_b2b", 1,0,2'd2,0,1, 32'h2004,0,32'hCAFEF00D, 0,0,0, 32'hCAFEF00D,1,0,0, 1,4'hF,0,32'h2004, 1);
        v[11] = mk("lw_tmo", 1,0,2'd2,0,1, 32'h2008,0,32'h77777777, 0,0,1, 32'h0,0,1,0, 1,4'hF,0,32'h2008, 4);
        v[12] = mk("alu_aft",0,0,2'd2,0,0, 32'h0ABC,0,0, 0,0,0, 32'h0ABC,1,0,0, 0,4'h0,0,0, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        v[13] = mk("lw_mis", 1,0,2'd2,0,1, 32'h3001,0,32'h11223344, 0,0,0, 32'h0,0,0,1, 0,4'h0,0,0, 0);
        v[14] = mk("lh_mis", 1,0,2'd1,0,1, 32'h3003,0,32'h87654321, 0,0,0, 32'h0,0,0,1, 0,4'h0,0,0, 0);
`else
        v[13] = mk("lw_mis", 1,0,2'd2,0,1, 32'h3001,0,32'h11223344, 0,0,0, 32'h11223344,1,0,0, 1,4'hF,0,32'h3000, 1);
        v[14] = mk("lh_mis", 1,0,2'd1,0,1, 32'h3003,0,32'h87654321, 0,0,0, 32'hFFFF8765,1,0,0, 1,4'b1100,0,32'h3002, 1);
`endif

        // reset values, with a load presented so the request gating is visible
        @(negedge clk);
        chk("rst.out_valid", 32'(out_valid), 32'h0);
        chk("rst.out_bus_rf_wr_en", 32'(out_bus.rf_wr_en), 32'h0);
        chk("rst.out_bus_result", out_bus.result, 32'h0);
        chk("rst.pulses", {30'b0, bus_err, misalign}, 32'h0);
        chk("rst.dmem_req", 32'(dmem.dmem_req), 32'h0);
        @(posedge clk);
        #1;
        in_valid = 1'b0; mem_rd = 1'b0;
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 15; i++)
            run_vec(v[i], i);
        in_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        neg(); step();
        neg(); step();
        chk("drain.sb_empty", 32'(sbq.size()), 32'h0);

        // reset while a granted load waits for rvalid; the late rvalid must be ignored
        gnt_dly = 0; rv_dly = 3; rv_never = 1'b0; mem_rdata = 32'h11111111;
        in_valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; mem_size = 2'd2; mem_uns = 1'b0;
        in_bus = '0; in_bus.rf_wr_en = 1'b1; in_bus.sel_res = 1'b1; in_bus.ex_out = 32'h2000;
        neg();
        chk("rstw.req", 32'(dmem.dmem_req), 32'h1);
        step();
        neg();
        chk("rstw.stall_in_wait", 32'(stall), 32'h1);
        chk("rstw.state_wait", 32'(dut.state_q), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b0; mem_rd = 1'b0;
        #1;
        chk("rstw.out_valid", 32'(out_valid), 32'h0);
        chk("rstw.state_idle", 32'(dut.state_q), 32'h0);
        chk("rstw.req_off", 32'(dmem.dmem_req), 32'h0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            neg();
            chk("rstw.no_late_out", 32'(out_valid), 32'h0);
            step();
        end
        chk("rstw.rvalid_consumed", 32'(pend), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline stage 3 (memory access) of the RV32I in-order pipeline. Consumes the `bus_stage2` record from the execute stage and its memory sideband, runs load/store transactions on a request/grant/rvalid data-memory port, and formats load data. Registers the outcome into the `bus_stage3` record for write-back. While a memory access is outstanding it stalls the upstream pipeline.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles an access may wait for `dmem_gnt`/`dmem_rvalid` before it is aborted with `bus_err`.
- `CNT_W`, default 8: width of the timeout counter. Must satisfy `TIMEOUT_CYCLES < 2**CNT_W`.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  — clock, rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `in_valid`  in  1  — `in_bus` holds a live instruction.
- `in_bus`  in  `bus_stage2`  — execute-stage record. `ex_out` is the address; `rf_rdata2` is the store data.
- `mem_rd`  in  1  — instruction is a load.
- `mem_wr`  in  1  — instruction is a store. Never asserted together with `mem_rd`.
- `mem_size`  in  2  — access size: 0 = byte, 1 = half, 2 = word.
- `mem_uns`  in  1  — load is zero-extended (LBU/LHU).
- `stall`  out  1  — upstream must hold `in_bus`, `in_valid` and the sideband stable.
- `out_valid`  out  1  — `out_bus` is a live instruction.
- `out_bus`  out  `bus_stage3`  — record for write-back.
- `dmem_req`  out  1 — request. `dmem_we` out 1 — write. `dmem_addr` out 32. `dmem_wdata` out 32. `dmem_be` out 4 — byte enables.
- `dmem_gnt`  in  1 — request accepted. `dmem_rvalid` in 1 — read data valid. `dmem_rdata` in 32.
- `bus_err`  out  1  — one-cycle pulse when an access is aborted by timeout.
- `misalign`  out  1  — one-cycle pulse when a misaligned access is trapped (see Configuration).

## Operation
- The FSM has two states:
  - `IDLE`: no load has been granted yet.
  - `WAIT`: a load has been granted and the stage is waiting for `dmem_rvalid`.
- `mem_op = in_valid & (mem_rd | mem_wr)`.
- `dmem_req = mem_op & (state == IDLE) & ~trap`. This is combinational and is held until `dmem_gnt`.
- `dmem_addr = in_bus.ex_out`.
- Store data and byte enables, with `a = addr[1:0]`:
  - byte: `dmem_wdata = {4{rdata2[7:0]}}`, `dmem_be = 1 << a`.
  - half: `dmem_wdata = {2{rdata2[15:0]}}`, `dmem_be = 3 << a`.
  - word: `dmem_wdata = rdata2`, `dmem_be = 4'hF`.
  - Loads drive `dmem_be` the same way.
- Store completion: completes in the cycle `dmem_gnt` is high. It does not wait for `rvalid`.
- Load completion:
  - `dmem_gnt` in `IDLE` moves the FSM to `WAIT`.
  - The load completes in the cycle `dmem_rvalid` is high while in `WAIT`.
  - Load data = `dmem_rdata >> (8*a)`, truncated to the access size, then sign-extended (or zero-extended if `mem_uns`).
  - `dmem_rvalid` while in `IDLE` is ignored.
- Non-memory instructions (`in_valid & ~mem_op`) complete in the same cycle they are presented.
- `stall = mem_op & ~complete`.
- On completion the output register loads the following from `in_bus` (same-named fields pass through):
  - `rf_wr_en`, `rd`, `sel_rf_wr`, `sel_pc`, `cmp_out`, `inc_pc`, `ecall`.
  - `result` = load data if `sel_res == 1`, else `ex_out`.
- Timeout counter:
  - Clears on completion.
  - Increments each cycle that `stall` is high.
  - When the count reaches `TIMEOUT_CYCLES`, the access completes forcibly: `bus_err` pulses, `out_bus.result = 0`, `out_bus.rf_wr_en = 0`, and the FSM returns to `IDLE`.
- Bubbles: a cycle with no completion registers `out_valid = 0`, `out_bus.rf_wr_en = 0`, `out_bus.ecall = 0`. Other fields are don't-care.
- There is no downstream backpressure; write-back always accepts.

## Timing
- Reset values:
  - Flops: `out_valid = 0`, `out_bus = '0`, `bus_err = 0`, `misalign = 0`, state `IDLE`, counter 0.
  - `dmem_req` is 0 while `rst` is high.
- Latency to `out_valid`:
  - Non-memory instruction: 1 cycle.
  - Store with `gnt` in the same cycle as `req`: 1 cycle.
  - Load with zero-wait memory: 2 cycles (`gnt` in cycle 0, `rvalid` in cycle 1).
  - Each wait cycle adds 1.
- Throughput: one instruction per cycle for back-to-back non-memory instructions and zero-wait stores.
- After a load completes, the next memory instruction may request in the following cycle.
- Reset asserted mid-access: the FSM and counter clear immediately, and the access is abandoned. The memory-side response is the memory's responsibility.
- `dmem_gnt` and `dmem_rvalid` are both high in `WAIT`: only `rvalid` is honoured.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A word access with `a != 0`, or a half access with `a[0] != 0`, sets `trap`.
  - No `dmem_req` is issued. The instruction completes in 1 cycle with `misalign` pulsed and `rf_wr_en = 0`.
- Undefined:
  - `misalign` is tied to 0.
  - The low address bits are masked to alignment (word `& ~3`, half `& ~1`) and the access proceeds normally.

## Test plan
- After reset, non-memory stream (`ex_out = 32'h1234`, `sel_res = 0`) → `out_valid` high one cycle later, `result = 32'h1234`, `stall` never high.
- SB with `ex_out = 32'h1003`, `rdata2 = 32'hAB` and `gnt` in the same cycle → `dmem_be = 4'b1000`, `dmem_wdata = 32'hABABABAB`, `dmem_we = 1`, 1-cycle latency.
- LH at `32'h2002` with `dmem_rdata = 32'h8001_0000`, `gnt` delayed 2 cycles, `rvalid` 1 cycle later → `stall` high for 3 cycles, `result = 32'hFFFF8001`. Same access as LHU → `32'h00008001`.
- LW whose `rvalid` never arrives with `TIMEOUT_CYCLES = 4` → after 4 stall cycles `bus_err` pulses and `rf_wr_en = 0`. The next instruction proceeds normally.
- LW at `32'h3001` → with `MEM_MISALIGN_TRAP_EN`: no `dmem_req`, `misalign` pulse. Without it: `dmem_addr = 32'h3000`, normal load.
- Assert `rst` while in `WAIT` → `out_valid = 0` and state `IDLE` immediately. A late `rvalid` after reset has no effect.
